// File: rtl/fifo_wr_arbiter.sv
// Two-requester round-robin arbiter that feeds a single FIFO write port.
// A grant is held for a whole packet. It is also released when the burst limit or the idle timeout is reached.
module fifo_wr_arbiter #(
    parameter int unsigned MAX_BURST = 16,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic       i_wr_clk,
    input  logic       resetn,
    input  logic       i_valid0,
    input  logic [7:0] i_data0,
    input  logic       i_last0,
    input  logic       i_valid1,
    input  logic [7:0] i_data1,
    input  logic       i_last1,
    output logic       o_ready0,
    output logic       o_ready1,
    input  logic       i_fifo_full,
    output logic       o_wr_en,
    output logic [7:0] o_wr_data,
    output logic [1:0] o_grant,
    output logic       o_timeout_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam logic [8:0] LP_MAX_BURST = 9'(MAX_BURST);
    localparam logic [8:0] LP_TIMEOUT   = 9'(TIMEOUT);

    state_t     r_state;
    logic       r_rr;
    logic [7:0] r_burst_cnt;
    logic [7:0] r_idle_cnt;
    logic       r_wr_en;
    logic [7:0] r_wr_data;
    logic [1:0] r_grant;
    logic       r_timeout_err;

    logic       w_own0;
    logic       w_own1;
    logic       w_valid;
    logic       w_last;
    logic [7:0] w_data;
    logic       w_xfer;
    logic [8:0] w_burst_next;
    logic [8:0] w_idle_next;
    logic       w_burst_done;
    logic       w_timeout;

    assign w_own0   = (r_state == OWN0);
    assign w_own1   = (r_state == OWN1);
    assign w_valid  = w_own1 ? i_valid1 : i_valid0;
    assign w_last   = w_own1 ? i_last1  : i_last0;
    assign w_data   = w_own1 ? i_data1  : i_data0;

    assign o_ready0 = w_own0 && !i_fifo_full;
    assign o_ready1 = w_own1 && !i_fifo_full;
    assign w_xfer   = (w_own0 || w_own1) && w_valid && !i_fifo_full;

    // Both counters stick at 255 rather than wrapping.
    assign w_burst_next = (r_burst_cnt == 8'hFF) ? 9'h0FF : ({1'b0, r_burst_cnt} + 9'd1);
    assign w_idle_next  = (r_idle_cnt  == 8'hFF) ? 9'h0FF : ({1'b0, r_idle_cnt}  + 9'd1);
    assign w_burst_done = (w_burst_next >= LP_MAX_BURST);
    assign w_timeout    = !w_valid && (w_idle_next >= LP_TIMEOUT);

    always_ff @(posedge i_wr_clk or negedge resetn) begin
        if (!resetn) begin
            r_state       <= IDLE;
            r_rr          <= 1'b0;
            r_burst_cnt   <= '0;
            r_idle_cnt    <= '0;
            r_wr_en       <= 1'b0;
            r_wr_data     <= '0;
            r_grant       <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_wr_en       <= w_xfer;
            r_timeout_err <= 1'b0;
            if (w_xfer) begin
                r_wr_data <= w_data;
            end

            case (r_state)
                IDLE: begin
                    r_burst_cnt <= '0;
                    r_idle_cnt  <= '0;
                    if (i_valid0 && (!i_valid1 || !r_rr)) begin
                        r_state <= OWN0;
                        r_grant <= 2'b01;
                    end else if (i_valid1) begin
                        r_state <= OWN1;
                        r_grant <= 2'b10;
                    end
                end

                OWN0, OWN1: begin
                    // A transfer needs valid and a timeout needs !valid, so the two cannot happen together.
                    if (w_xfer) begin
                        r_burst_cnt <= w_burst_next[7:0];
                        r_idle_cnt  <= '0;
                        if (w_last || w_burst_done) begin
                            r_state <= IDLE;
                            r_grant <= '0;
                            r_rr    <= w_own0;
                        end
                    end else if (!w_valid) begin
                        r_idle_cnt <= w_idle_next[7:0];
                        if (w_timeout) begin
                            r_state       <= IDLE;
                            r_grant       <= '0;
                            r_rr          <= w_own0;
                            r_timeout_err <= 1'b1;
                        end
                    end
                end

                default: begin
                    r_state <= IDLE;
                    r_grant <= '0;
                end
            endcase
        end
    end

    assign o_wr_en       = r_wr_en;
    assign o_wr_data     = r_wr_data;
    assign o_grant       = r_grant;
    assign o_timeout_err = r_timeout_err;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter.
// The stimulus side holds a packet-level reference model, and separate monitors compare the DUT outputs against queued expectations.
module tb_fifo_wr_arbiter;

    localparam int unsigned MB = 16;
    localparam int unsigned TO = 4;

    logic       clk = 1'b0;
    logic       resetn = 1'b1;
    logic       i_valid0 = 1'b0, i_valid1 = 1'b0;
    logic [7:0] i_data0 = '0, i_data1 = '0;
    logic       i_last0 = 1'b0, i_last1 = 1'b0;
    logic       i_fifo_full = 1'b0;
    logic       o_ready0, o_ready1, o_wr_en, o_timeout_err;
    logic [7:0] o_wr_data;
    logic [1:0] o_grant;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.MAX_BURST(MB), .TIMEOUT(TO)) dut (
        .i_wr_clk      (clk),
        .resetn        (resetn),
        .i_valid0      (i_valid0),
        .i_data0       (i_data0),
        .i_last0       (i_last0),
        .i_valid1      (i_valid1),
        .i_data1       (i_data1),
        .i_last1       (i_last1),
        .o_ready0      (o_ready0),
        .o_ready1      (o_ready1),
        .i_fifo_full   (i_fifo_full),
        .o_wr_en       (o_wr_en),
        .o_wr_data     (o_wr_data),
        .o_grant       (o_grant),
        .o_timeout_err (o_timeout_err)
    );

    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } byte_t;

    typedef struct packed {
        logic [1:0] g;
        logic       we;
        logic       te;
    } st_t;

    byte_t      q0[$];
    byte_t      q1[$];
    st_t        st_q[$];
    logic [1:0] rdy_q[$];
    logic [7:0] wq[$];

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: the current owner (-1 when idle), the fairness pointer,
    // and the bytes-this-grant and idle-cycles-this-grant counts.
    int m_owner = -1;
    int m_rr    = 0;
    int m_bcnt  = 0;
    int m_icnt  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic do_cycle(input bit full, input bit rst, input bit g0, input bit g1);
        bit         v[2];
        byte_t      b[2];
        st_t        s;
        logic [1:0] r;
        int         n;
        @(negedge clk);
        v[0] = g0 && (q0.size() > 0);
        v[1] = g1 && (q1.size() > 0);
        b[0] = v[0] ? q0[0] : {8'($urandom), 1'($urandom)};
        b[1] = v[1] ? q1[0] : {8'($urandom), 1'($urandom)};
        resetn      = !rst;
        i_valid0    = v[0];
        i_data0     = b[0].d;
        i_last0     = b[0].l;
        i_valid1    = v[1];
        i_data1     = b[1].d;
        i_last1     = b[1].l;
        i_fifo_full = full;
        s = '0;
        r = 2'b00;
        if (rst) begin
            m_owner = -1;
            m_rr    = 0;
            m_bcnt  = 0;
            m_icnt  = 0;
        end else if (m_owner < 0) begin
            if (v[0] && v[1]) m_owner = m_rr;
            else if (v[0])    m_owner = 0;
            else if (v[1])    m_owner = 1;
            m_bcnt = 0;
            m_icnt = 0;
        end else begin
            n    = m_owner;
            r[n] = !full;
            if (v[n] && !full) begin
                wq.push_back(b[n].d);
                s.we = 1'b1;
                if (n == 0) void'(q0.pop_front());
                else        void'(q1.pop_front());
                m_bcnt = (m_bcnt < 255) ? m_bcnt + 1 : 255;
                m_icnt = 0;
                if (b[n].l || m_bcnt >= int'(MB)) begin
                    m_rr    = 1 - n;
                    m_owner = -1;
                end
            end else if (!v[n]) begin
                m_icnt = (m_icnt < 255) ? m_icnt + 1 : 255;
                if (m_icnt >= int'(TO)) begin
                    s.te    = 1'b1;
                    m_rr    = 1 - n;
                    m_owner = -1;
                end
            end
        end
        s.g = (m_owner == 0) ? 2'b01 : (m_owner == 1) ? 2'b10 : 2'b00;
        rdy_q.push_back(r);
        st_q.push_back(s);
    endtask

    task automatic reset_dut();
        do_cycle(1'b0, 1'b1, 1'b0, 1'b0);
        do_cycle(1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic drain(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            if (q0.size() == 0 && q1.size() == 0 && m_owner < 0) break;
            do_cycle(1'b0, 1'b0, 1'b1, 1'b1);
        end
    endtask

    initial begin : mon_ready
        logic [1:0] r;
        forever begin
            @(negedge clk);
            #2;
            if (rdy_q.size() > 0) begin
                r = rdy_q.pop_front();
                chk("ready0", {31'd0, o_ready0}, {31'd0, r[0]});
                chk("ready1", {31'd0, o_ready1}, {31'd0, r[1]});
            end
        end
    end

    initial begin : mon_out
        st_t s;
        forever begin
            @(posedge clk);
            #1;
            if (st_q.size() > 0) begin
                s = st_q.pop_front();
                chk("grant", {30'd0, o_grant}, {30'd0, s.g});
                chk("wr_en", {31'd0, o_wr_en}, {31'd0, s.we});
                chk("timeout_err", {31'd0, o_timeout_err}, {31'd0, s.te});
            end
            if (o_wr_en) begin
                if (wq.size() == 0) begin
                    n_chk++;
                    $display("FAIL wr_unexpected: got write %0h expected no write at %0t", o_wr_data, $time);
                end else begin
                    chk("wr_data", {24'd0, o_wr_data}, {24'd0, wq.pop_front()});
                end
            end
        end
    end

    initial begin : stim
        int full_left;
        #1 resetn = 1'b0;
        #2;
        chk("rst_grant", {30'd0, o_grant}, 32'd0);
        chk("rst_wr_en", {31'd0, o_wr_en}, 32'd0);
        chk("rst_wr_data", {24'd0, o_wr_data}, 32'd0);
        chk("rst_timeout", {31'd0, o_timeout_err}, 32'd0);
        chk("rst_ready0", {31'd0, o_ready0}, 32'd0);
        chk("rst_ready1", {31'd0, o_ready1}, 32'd0);
        reset_dut();

        // Single three-byte packet from requester 0.
        q0.push_back({8'hA1, 1'b0});
        q0.push_back({8'hA2, 1'b0});
        q0.push_back({8'hA3, 1'b1});
        drain(20);

        // Both requesters contending with 2-byte packets.
        reset_dut();
        q0.push_back({8'h10, 1'b0}); q0.push_back({8'h11, 1'b1});
        q0.push_back({8'h12, 1'b0}); q0.push_back({8'h13, 1'b1});
        q1.push_back({8'h20, 1'b0}); q1.push_back({8'h21, 1'b1});
        drain(40);

        // Burst limit: 20 bytes without a last flag while requester 1 waits.
        reset_dut();
        for (int i = 0; i < 20; i++) q0.push_back({8'(8'h40 + i), 1'b0});
        q1.push_back({8'h80, 1'b0}); q1.push_back({8'h81, 1'b1});
        drain(100);

        // The FIFO reports full for 5 cycles in the middle of a packet.
        reset_dut();
        for (int i = 0; i < 6; i++) q0.push_back({8'(8'h60 + i), (i == 5)});
        repeat (3) do_cycle(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (5) do_cycle(1'b1, 1'b0, 1'b1, 1'b0);
        drain(30);

        // Timeout: a single byte without last, after which valid drops.
        reset_dut();
        q0.push_back({8'h77, 1'b0});
        drain(20);

        // Reset is asserted while requester 1 has a byte in flight.
        reset_dut();
        q1.push_back({8'h91, 1'b0}); q1.push_back({8'h92, 1'b0}); q1.push_back({8'h93, 1'b1});
        do_cycle(1'b0, 1'b0, 1'b0, 1'b1);
        do_cycle(1'b0, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #3 resetn = 1'b0;
        #1;
        chk("midrst_grant", {30'd0, o_grant}, 32'd0);
        chk("midrst_wr_en", {31'd0, o_wr_en}, 32'd0);
        chk("midrst_wr_data", {24'd0, o_wr_data}, 32'd0);
        chk("midrst_timeout", {31'd0, o_timeout_err}, 32'd0);
        chk("midrst_ready1", {31'd0, o_ready1}, 32'd0);
        q1.delete();
        reset_dut();
        q1.push_back({8'hB0, 1'b1});
        q0.push_back({8'hC0, 1'b1});
        drain(20);

        // Randomised traffic.
        full_left = 0;
        for (int c = 0; c < 3000; c++) begin
            bit f;
            if (q0.size() < 3 && $urandom_range(0, 3) == 0)
                q0.push_back({8'($urandom), ($urandom_range(0, 3) == 0)});
            if (q1.size() < 3 && $urandom_range(0, 3) == 0)
                q1.push_back({8'($urandom), ($urandom_range(0, 3) == 0)});
            if (full_left > 0) begin
                f = 1'b1;
                full_left--;
            end else begin
                f = ($urandom_range(0, 9) == 0);
                if ($urandom_range(0, 29) == 0) full_left = $urandom_range(1, 8);
            end
            do_cycle(f, ($urandom_range(0, 399) == 0),
                     ($urandom_range(0, 7) != 0), ($urandom_range(0, 7) != 0));
        end
        drain(200);

        repeat (3) @(posedge clk);
        #3;
        chk("wq_empty", wq.size(), 32'd0);
        chk("st_q_empty", st_q.size(), 32'd0);
        chk("rdy_q_empty", rdy_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
